// File: rtl/mem_bus_arbiter_pkg.sv
// Shared bus command encodings and the arbiter state type used by the
// unified-memory arbiter.
package mem_bus_arbiter_pkg;

    localparam logic [1:0] BUS_NONE  = 2'b00;
    localparam logic [1:0] BUS_LOAD  = 2'b01;
    localparam logic [1:0] BUS_STORE = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_I,
        ISSUE_D,
        WAIT_I,
        WAIT_D
    } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and the data
// stage: data-first with a bounded fetch-starvation guard, one transaction in flight.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  if_cmd,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic [31:0] if_rdata,
    output logic        if_done,
    output logic        if_stall,
    input  logic [1:0]  d_cmd,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        d_stall,
    output logic [1:0]  mem_cmd,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arb_state_e state, state_nxt;
    logic       discard, discard_nxt;
    logic [3:0] starve_cnt, starve_nxt;
    logic       i_req, d_req;
    logic       grant_i, grant_d;

    assign i_req = (if_cmd != BUS_NONE);
    assign d_req = (d_cmd != BUS_NONE);

    always_comb begin
        state_nxt   = state;
        discard_nxt = discard;
        grant_i     = 1'b0;
        grant_d     = 1'b0;
        if_done     = 1'b0;
        d_done      = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && starve_cnt < STARVE_LIM) begin
                    grant_d   = 1'b1;
                    state_nxt = ISSUE_D;
                end else if (i_req && !if_flush) begin
                    grant_i   = 1'b1;
                    state_nxt = ISSUE_I;
                end else if (d_req) begin
                    grant_d   = 1'b1;
                    state_nxt = ISSUE_D;
                end
            end
            ISSUE_I: begin
                // An accepted fetch cannot be recalled, so a flush only marks
                // its response for dropping; an unaccepted one is withdrawn.
                if (mem_ready) begin
                    state_nxt = WAIT_I;
                    if (if_flush) discard_nxt = 1'b1;
                end else if (if_flush) begin
                    state_nxt = IDLE;
                end
            end
            ISSUE_D: begin
                if (mem_ready) state_nxt = WAIT_D;
            end
            WAIT_I: begin
                if (mem_rsp_valid) begin
                    if_done     = !discard && !if_flush;
                    discard_nxt = 1'b0;
                    state_nxt   = IDLE;
                end else if (if_flush) begin
                    discard_nxt = 1'b1;
                end
            end
            WAIT_D: begin
                if (mem_rsp_valid) begin
                    d_done    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        starve_nxt = starve_cnt;
        if (!i_req || grant_i)
            starve_nxt = 4'd0;
        else if (grant_d && starve_cnt < STARVE_LIM)
            starve_nxt = starve_cnt + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            discard    <= 1'b0;
            starve_cnt <= 4'd0;
        end else begin
            state      <= state_nxt;
            discard    <= discard_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // Bus command is presented only while an ISSUE state is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_cmd   <= BUS_NONE;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
        end else if (grant_d) begin
            mem_cmd   <= d_cmd;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
        end else if (grant_i) begin
            mem_cmd   <= BUS_LOAD;
            mem_addr  <= if_addr;
        end else if (state_nxt != ISSUE_I && state_nxt != ISSUE_D) begin
            mem_cmd   <= BUS_NONE;
        end
    end

    assign if_rdata = mem_rdata;
    assign d_rdata  = mem_rdata;
    assign if_stall = i_req && !if_done;
    assign d_stall  = d_req && !d_done;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed requests push expected grants
// and responses; a negedge monitor pops and compares as the DUT produces them.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  if_cmd;
    logic [31:0] if_addr;
    logic        if_flush;
    logic [31:0] if_rdata;
    logic        if_done, if_stall;
    logic [1:0]  d_cmd;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        d_done, d_stall;
    logic [1:0]  mem_cmd;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready, mem_rsp_valid;
    logic [31:0] mem_rdata;

    mem_bus_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_cmd(if_cmd), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
        .d_cmd(d_cmd), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
        .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic [1:0] cmd; logic [31:0] addr; logic [31:0] wdata; } grant_t;
    typedef struct { logic chk; logic [31:0] data; } rsp_t;
    typedef struct { int due; logic [31:0] data; } pend_t;

    grant_t      exp_grant[$];
    logic [31:0] exp_if[$];
    rsp_t        exp_d[$];
    pend_t       pend_q[$];
    logic [31:0] mem_model [logic [31:0]];

    int checks = 0;
    int failures = 0;
    int cyc_n = 0;
    int mem_lat = 1;
    bit stray_ok = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: accepts at negedge, returns in order after mem_lat cycles.
    initial begin
        pend_t p;
        mem_rsp_valid = 1'b0;
        mem_rdata     = 32'd0;
        forever begin
            @(posedge clk);
            cyc_n++;
            #1;
            if (pend_q.size() > 0 && pend_q[0].due <= cyc_n) begin
                mem_rsp_valid = 1'b1;
                mem_rdata     = pend_q[0].data;
                void'(pend_q.pop_front());
            end else begin
                mem_rsp_valid = 1'b0;
                mem_rdata     = 32'd0;
            end
            @(negedge clk);
            if (mem_cmd != BUS_NONE && mem_ready) begin
                p.due = cyc_n + mem_lat;
                if (mem_cmd == BUS_STORE) begin
                    mem_model[mem_addr] = mem_wdata;
                    p.data = 32'd0;
                end else begin
                    p.data = mem_model.exists(mem_addr) ? mem_model[mem_addr] : ~mem_addr;
                end
                pend_q.push_back(p);
            end
        end
    end

    // Monitor: grants and done pulses against the expectation queues.
    always @(negedge clk) begin
        grant_t      g;
        logic [31:0] e;
        rsp_t        r;
        if (mem_cmd != BUS_NONE && mem_ready) begin
            checks++;
            if (exp_grant.size() == 0) begin
                failures++;
                $display("FAIL grant_unexpected: got cmd %0d addr %h want none", mem_cmd, mem_addr);
            end else begin
                g = exp_grant.pop_front();
                if (mem_cmd !== g.cmd || mem_addr !== g.addr ||
                    (g.cmd == BUS_STORE && mem_wdata !== g.wdata)) begin
                    failures++;
                    $display("FAIL grant: got cmd %0d addr %h wdata %h want cmd %0d addr %h wdata %h",
                             mem_cmd, mem_addr, mem_wdata, g.cmd, g.addr, g.wdata);
                end
            end
        end
        if (if_done) begin
            checks++;
            if (exp_if.size() == 0) begin
                failures++;
                $display("FAIL if_done_unexpected: got rdata %h want no done", if_rdata);
            end else begin
                e = exp_if.pop_front();
                if (if_rdata !== e) begin
                    failures++;
                    $display("FAIL if_rdata: got %h want %h", if_rdata, e);
                end
            end
        end
        if (d_done) begin
            checks++;
            if (exp_d.size() == 0) begin
                failures++;
                $display("FAIL d_done_unexpected: got rdata %h want no done", d_rdata);
            end else begin
                r = exp_d.pop_front();
                if (r.chk && d_rdata !== r.data) begin
                    failures++;
                    $display("FAIL d_rdata: got %h want %h", d_rdata, r.data);
                end
            end
        end
        if (mem_rsp_valid && !stray_ok)
            assert (dut.state == WAIT_I || dut.state == WAIT_D)
            else begin
                failures++;
                $display("FAIL rsp_outside_wait: got state %0d want WAIT", dut.state);
            end
    end

    task automatic do_if(input logic [31:0] a);
        logic got;
        got = 1'b0;
        if_cmd = BUS_LOAD;
        if_addr = a;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (if_done) begin got = 1'b1; break; end
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL if_timeout: got no if_done want done for %h", a);
        end
        tick();
        if_cmd = BUS_NONE;
    endtask

    task automatic do_d(input logic [1:0] c, input logic [31:0] a, input logic [31:0] wd);
        logic got;
        got = 1'b0;
        d_cmd = c;
        d_addr = a;
        d_wdata = wd;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (d_done) begin got = 1'b1; break; end
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL d_timeout: got no d_done want done for %h", a);
        end
        tick();
        d_cmd = BUS_NONE;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ifcnt;
        logic got;
        mem_model[32'h100] = 32'h0000_0013;
        mem_model[32'h200] = 32'h00A0_0093;
        mem_model[32'h080] = 32'h1234_5678;
        mem_model[32'h300] = 32'hBADF_00D0;
        mem_model[32'h600] = 32'h0600_0600;
        mem_model[32'h604] = 32'h0604_0604;
        for (int k = 0; k < 6; k++) mem_model[32'h500 + 32'(4*k)] = 32'hD000_0000 + 32'(k);

        rst_n = 1'b0; if_cmd = BUS_LOAD; if_addr = 32'h0; if_flush = 1'b0;
        d_cmd = BUS_NONE; d_addr = 32'h0; d_wdata = 32'h0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_cmd", 32'(mem_cmd), 32'(BUS_NONE));
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_if_done", 32'(if_done), 32'd0);
        chk("rst_d_done", 32'(d_done), 32'd0);
        chk("rst_if_stall_comb", 32'(if_stall), 32'd1);
        chk("rst_d_stall", 32'(d_stall), 32'd0);
        if_cmd = BUS_NONE;
        tick();
        rst_n = 1'b1;
        tick();

        // IF-only fetch, best-case latency
        mem_lat = 1;
        exp_grant.push_back('{BUS_LOAD, 32'h100, 32'h0});
        exp_if.push_back(32'h0000_0013);
        tick();
        if_cmd = BUS_LOAD; if_addr = 32'h100;
        @(negedge clk);
        chk("c0_if_stall", 32'(if_stall), 32'd1);
        chk("c0_mem_cmd", 32'(mem_cmd), 32'(BUS_NONE));
        tick();
        @(negedge clk);
        chk("c1_mem_cmd", 32'(mem_cmd), 32'(BUS_LOAD));
        chk("c1_mem_addr", mem_addr, 32'h100);
        chk("c1_if_stall", 32'(if_stall), 32'd1);
        tick();
        @(negedge clk);
        chk("c2_if_done", 32'(if_done), 32'd1);
        chk("c2_if_rdata", if_rdata, 32'h13);
        chk("c2_if_stall", 32'(if_stall), 32'd0);
        tick();
        if_cmd = BUS_NONE;
        @(negedge clk);
        chk("c3_mem_cmd", 32'(mem_cmd), 32'(BUS_NONE));

        // Conflict: store wins, fetch follows; then read the store back
        tick();
        exp_grant.push_back('{BUS_STORE, 32'h40, 32'hDEAD_BEEF});
        exp_grant.push_back('{BUS_LOAD, 32'h200, 32'h0});
        exp_d.push_back('{1'b0, 32'h0});
        exp_if.push_back(32'h00A0_0093);
        fork
            do_d(BUS_STORE, 32'h40, 32'hDEAD_BEEF);
            do_if(32'h200);
        join
        exp_grant.push_back('{BUS_LOAD, 32'h40, 32'h0});
        exp_d.push_back('{1'b1, 32'hDEAD_BEEF});
        do_d(BUS_LOAD, 32'h40, 32'h0);

        // Starvation guard: D,D,D,D,I,D,D,I
        tick();
        for (int k = 0; k < 4; k++) exp_grant.push_back('{BUS_LOAD, 32'h500 + 32'(4*k), 32'h0});
        exp_grant.push_back('{BUS_LOAD, 32'h600, 32'h0});
        exp_grant.push_back('{BUS_LOAD, 32'h510, 32'h0});
        exp_grant.push_back('{BUS_LOAD, 32'h514, 32'h0});
        exp_grant.push_back('{BUS_LOAD, 32'h604, 32'h0});
        for (int k = 0; k < 6; k++) exp_d.push_back('{1'b1, 32'hD000_0000 + 32'(k)});
        exp_if.push_back(32'h0600_0600);
        exp_if.push_back(32'h0604_0604);
        fork
            begin
                for (int k = 0; k < 6; k++) do_d(BUS_LOAD, 32'h500 + 32'(4*k), 32'h0);
            end
            begin
                do_if(32'h600);
                do_if(32'h604);
            end
        join

        // Flush during WAIT_I: fetch response consumed silently
        tick();
        mem_lat = 3;
        exp_grant.push_back('{BUS_LOAD, 32'h300, 32'h0});
        exp_grant.push_back('{BUS_LOAD, 32'h80, 32'h0});
        exp_d.push_back('{1'b1, 32'h1234_5678});
        if_cmd = BUS_LOAD; if_addr = 32'h300;
        tick();
        tick();
        @(negedge clk);
        chk("fw_state_wait_i", 32'(dut.state), 32'(WAIT_I));
        tick();
        if_flush = 1'b1; if_cmd = BUS_NONE;
        tick();
        if_flush = 1'b0; d_cmd = BUS_LOAD; d_addr = 32'h80;
        ifcnt = 0; got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (if_done) ifcnt++;
            if (d_done) begin got = 1'b1; break; end
            tick();
        end
        chk("fw_no_if_done", 32'(ifcnt), 32'd0);
        chk("fw_d_done_seen", 32'(got), 32'd1);
        tick();
        d_cmd = BUS_NONE;

        // Flush during ISSUE_I with memory stalled: request withdrawn
        tick();
        mem_lat = 1;
        mem_ready = 1'b0;
        if_cmd = BUS_LOAD; if_addr = 32'h400;
        tick();
        if_flush = 1'b1; if_cmd = BUS_NONE;
        @(negedge clk);
        chk("fi_mem_cmd_held", 32'(mem_cmd), 32'(BUS_LOAD));
        tick();
        if_flush = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        chk("fi_mem_cmd_none", 32'(mem_cmd), 32'(BUS_NONE));
        chk("fi_state_idle", 32'(dut.state), 32'(IDLE));
        repeat (3) tick();
        @(negedge clk);
        chk("fi_no_pending", 32'(pend_q.size()), 32'd0);

        // Reset during WAIT_D, stray response afterwards
        tick();
        mem_lat = 3;
        exp_grant.push_back('{BUS_LOAD, 32'h80, 32'h0});
        d_cmd = BUS_LOAD; d_addr = 32'h80;
        tick();
        tick();
        @(negedge clk);
        chk("rw_state_wait_d", 32'(dut.state), 32'(WAIT_D));
        tick();
        rst_n = 1'b0; d_cmd = BUS_NONE; stray_ok = 1'b1;
        @(negedge clk);
        chk("rw_state_idle", 32'(dut.state), 32'(IDLE));
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rw_stray_d_done", 32'(d_done), 32'd0);
        chk("rw_stray_if_done", 32'(if_done), 32'd0);
        chk("rw_mem_cmd", 32'(mem_cmd), 32'(BUS_NONE));
        chk("rw_mem_addr", mem_addr, 32'h0);
        chk("rw_mem_wdata", mem_wdata, 32'h0);
        chk("rw_d_stall", 32'(d_stall), 32'd0);
        tick();
        stray_ok = 1'b0;

        // Normal operation after reset
        mem_lat = 1;
        exp_grant.push_back('{BUS_LOAD, 32'h100, 32'h0});
        exp_if.push_back(32'h0000_0013);
        do_if(32'h100);

        repeat (5) tick();
        chk("end_exp_grant_empty", 32'(exp_grant.size()), 32'd0);
        chk("end_exp_if_empty", 32'(exp_if.size()), 32'd0);
        chk("end_exp_d_empty", 32'(exp_d.size()), 32'd0);
        chk("end_pend_empty", 32'(pend_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares one single-ported unified memory between the IF stage (instruction fetch) and the MEM stage (loads and stores). It sits between the processor's two memory-facing interfaces and the memory. It runs one transaction at a time, gives data accesses priority with a bounded fetch-starvation guard, and produces per-requester done and stall signals. It also discards a fetch response when a taken branch flushes the front end.

## Interface
- `STARVE_MAX`, default 4: maximum number of consecutive data grants allowed while a fetch is pending. Legal range is 1..15.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous reset, active-low.
- `if_cmd` in 2: fetch command. `BUS_NONE` means no request; any other value is treated as `BUS_LOAD`.
- `if_addr` in 32: fetch address.
- `if_flush` in 1: a taken branch has redirected fetch this cycle.
- `if_rdata` out 32: fetched instruction, valid when `if_done` is high.
- `if_done` out 1: one-cycle pulse when the fetch completes.
- `if_stall` out 1: fetch pending and not done this cycle.
- `d_cmd` in 2: data command, one of `BUS_NONE`, `BUS_LOAD` or `BUS_STORE`.
- `d_addr` in 32: data address.
- `d_wdata` in 32: store data.
- `d_rdata` out 32: load data, valid when `d_done` is high.
- `d_done` out 1: one-cycle completion pulse.
- `d_stall` out 1: data request pending and not done this cycle.
- `mem_cmd` out 2: command to memory.
- `mem_addr` out 32: address to memory.
- `mem_wdata` out 32: write data to memory.
- `mem_ready` in 1: memory accepts `mem_cmd` this cycle.
- `mem_rsp_valid` in 1: memory response. Exactly one response per accepted command, in order, at least 1 cycle after acceptance.
- `mem_rdata` in 32: response data.

## Operation
- Requester contract: each requester holds cmd, addr and wdata stable from assertion until its done pulse. The requester may change them the cycle after done. A flush exempts IF from this rule.
- FSM states: `IDLE`, `ISSUE_I`, `ISSUE_D`, `WAIT_I`, `WAIT_D`.
- `IDLE` arbitration:
  - If `d_cmd` is not `BUS_NONE` and `starve_cnt` is below `STARVE_MAX`, go to `ISSUE_D`.
  - Else if `if_cmd` is not `BUS_NONE` and `if_flush` is low, go to `ISSUE_I`.
  - Else if a data request is pending, go to `ISSUE_D`.
  - Else stay in `IDLE`.
  - On every transition into an ISSUE state, latch the request's command, address and data into the `mem_*` output registers.
- `ISSUE_x`: drive the latched command. When `mem_ready` is high, go to `WAIT_x`.
- `ISSUE_I` with `if_flush` high:
  - If `mem_ready` is also high, go to `WAIT_I` and set `discard`.
  - Otherwise go to `IDLE`. The request is withdrawn and `mem_cmd` is `BUS_NONE` in the next cycle.
- `WAIT_x` on `mem_rsp_valid`:
  - `x_done` = 1 combinationally that cycle.
  - `x_rdata` = `mem_rdata` that cycle.
  - Next state is `IDLE`.
  - In `WAIT_I` with `discard` set, `if_done` stays 0. `discard` clears when the response arrives.
  - `if_flush` while in `WAIT_I` sets `discard`.
  - A store also completes on `mem_rsp_valid`; `d_rdata` is then don't-care.
- `starve_cnt` (4 bits):
  - Increments on each grant to data while `if_cmd` is not `BUS_NONE`.
  - Clears on a grant to IF.
  - Clears in any cycle where `if_cmd` is `BUS_NONE`.
  - Saturates at `STARVE_MAX`.
- `if_stall` = (`if_cmd` is not `BUS_NONE`) and not `if_done`. `d_stall` is the same for the data side.
- `mem_rsp_valid` outside a `WAIT` state is ignored. A bench assertion flags it.

## Timing
- Reset values:
  - State `IDLE`, `discard` = 0, `starve_cnt` = 0.
  - `mem_cmd` = `BUS_NONE`, `mem_addr` = 0, `mem_wdata` = 0.
  - Done outputs 0. Stall outputs follow their combinational definition.
- Reset mid-transaction: return to `IDLE` immediately. A response that arrives later is ignored.
- Best-case latency:
  - Request visible in cycle N.
  - `mem_cmd` valid in cycle N+1, accepted in N+1.
  - Response in N+2, done pulse in N+2.
  - Next arbitration happens in N+3 (`IDLE`).
- `mem_cmd`, `mem_addr` and `mem_wdata` are registered and held constant throughout `ISSUE_x`.
- In `WAIT_x` and `IDLE`, `mem_cmd` = `BUS_NONE`.
- Simultaneous IF and data requests in `IDLE`: data wins unless `starve_cnt` equals `STARVE_MAX`.
- `if_flush` in the same cycle that `WAIT_I` sees the response: `if_done` is suppressed.

## Structure
- `BUS_NONE`, `BUS_LOAD` and `BUS_STORE` come from the shared system defines.
- Add an `arb_state_e` enum typedef to the shared package alongside them.
- Single module, no sub-modules. The FSM, starvation counter and output registers are all local.

## Test plan
- IF-only: `if_addr`=0x100 with a memory returning 0x00000013 after 1 cycle -> `mem_cmd`=LOAD at 0x100 in cycle 1, `if_done` and `if_rdata`=0x13 in cycle 2, `if_stall` high in cycles 0-1.
- Conflict: IF 0x200 and data store to 0x40 with data 0xDEADBEEF in the same cycle -> store issued first with `mem_wdata`=0xDEADBEEF; IF issued after `d_done`.
- Starvation, `STARVE_MAX`=4: IF and data requesting continuously -> grant sequence D, D, D, D, I, D, ... .
- Flush in `WAIT_I` with memory latency 3 -> no `if_done`; the response is consumed; a following data load to 0x80 returns its own data, not the fetch data.
- Flush in `ISSUE_I` with `mem_ready`=0 -> `mem_cmd`=`BUS_NONE` next cycle, state `IDLE`, no response expected.
- `rst_n` low during `WAIT_D`, then a stray `mem_rsp_valid` after release -> `d_done` stays 0 and all outputs hold reset values.
